// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pkg                                                    |
// | Description : Shared types and constants for the instruction fetch stage:  |
// |               FSM state encoding, prefetch queue entry layout, default     |
// |               reset PC / queue depth, and a saturating counter helper      |
// |               used by the optional FETCH_PERF_EN counters.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned FETCH_ISIZE    = 16;
  localparam int unsigned FETCH_ASIZE    = 16;
  localparam int unsigned FETCH_QDEPTH   = 2;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

  // IDLE    : no request outstanding
  // WAIT    : request outstanding, its data will be queued
  // DISCARD : request outstanding, but it belongs to a flushed path
  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_e;

  // Queue entry at default widths; pc sits in the upper half.
  typedef struct packed {
    logic [FETCH_ASIZE-1:0] pc;
    logic [FETCH_ISIZE-1:0] instr;
  } fetch_entry_t;

  // 16-bit add that sticks at FFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Synchronous FIFO holding prefetched {pc, instr} entries.     |
// |               Flush has priority over push and pop. Push while full is     |
// |               accepted only when a pop happens in the same cycle.          |
// | Ports       : clk, rst      - clock, synchronous active-high reset         |
// |               i_push/i_data - write an entry                               |
// |               i_pop         - drop the head entry                          |
// |               i_flush       - empty the queue                              |
// |               o_data        - head entry                                   |
// |               o_count       - occupancy (0..DEPTH)                         |
// |               o_full/o_empty- occupancy flags                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop frees the slot the push needs, so full+pop+push is legal.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Issues one instruction-memory       |
// |               request at a time, buffers returned words with their PCs in  |
// |               a prefetch queue, and executes redirect (PCctrl) and stall   |
// |               (PChold) from control.                                       |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               imem_req/imem_addr  - memory request and its address         |
// |               imem_ack/imem_rdata - memory completion and data             |
// |               PCctrl/PCtarget     - redirect and target address            |
// |               PChold              - decode stall, blocks the pop           |
// |               Instr/InstrPC       - head-of-queue instruction and PC       |
// |               InstrValid          - queue non-empty                        |
// |               perf_fetch_cnt      - accepted pushes   (FETCH_PERF_EN only) |
// |               perf_flush_cnt      - discarded entries (FETCH_PERF_EN only) |
// | Config      : FETCH_PERF_EN adds the two saturating perf counters.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      ISIZE    = FETCH_ISIZE,
  parameter int unsigned      ASIZE    = FETCH_ASIZE,
  parameter int unsigned      QDEPTH   = FETCH_QDEPTH,
  parameter logic [ASIZE-1:0] RESET_PC = ASIZE'(FETCH_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [ASIZE-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [ISIZE-1:0] imem_rdata,
  input  logic             PCctrl,
  input  logic [ASIZE-1:0] PCtarget,
  input  logic             PChold,
  output logic [ISIZE-1:0] Instr,
  output logic [ASIZE-1:0] InstrPC,
  output logic             InstrValid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]      perf_fetch_cnt,
  output logic [15:0]      perf_flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = ASIZE + ISIZE;
  localparam logic [CW-1:0] C_QDEPTH = CW'(QDEPTH);

  localparam logic [1:0] S_IDLE    = FS_IDLE;
  localparam logic [1:0] S_WAIT    = FS_WAIT;
  localparam logic [1:0] S_DISCARD = FS_DISCARD;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ASIZE-1:0] r_fetch_pc;
  logic [ASIZE-1:0] w_fetch_pc_nxt;
  logic [ASIZE-1:0] r_disc_addr;
  logic [ASIZE-1:0] w_disc_addr_nxt;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_after;
  logic [EW-1:0]    w_head;

  // Redirect wins over everything: no pop, no push, queue flushed.
  assign w_pop  = !w_empty && !PChold && !PCctrl;
  assign w_push = (r_state == S_WAIT) && imem_ack && !PCctrl;

  // Occupancy once this cycle's push/pop has landed; decides whether
  // another request may be issued back-to-back.
  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (PCctrl),
    .i_data  ({r_fetch_pc, imem_rdata}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_disc_addr_nxt = r_disc_addr;
    if (PCctrl) begin
      w_fetch_pc_nxt = PCtarget;
      if (r_state == S_WAIT) begin
        if (imem_ack) begin
          // The request just completed; its data is dropped.
          w_state_nxt = S_IDLE;
        end else begin
          // Keep the in-flight address on the bus until its ack arrives.
          w_state_nxt     = S_DISCARD;
          w_disc_addr_nxt = r_fetch_pc;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_full) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            w_fetch_pc_nxt = r_fetch_pc + ASIZE'(1);
            if (w_count_after >= C_QDEPTH) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          // fetch_pc already holds the redirect target.
          if (imem_ack) begin
            w_state_nxt = S_WAIT;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_disc_addr <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_disc_addr <= w_disc_addr_nxt;
    end
  end

  assign imem_req   = (r_state == S_WAIT) || (r_state == S_DISCARD);
  assign imem_addr  = (r_state == S_DISCARD) ? r_disc_addr : r_fetch_pc;
  assign InstrValid = !w_empty;
  assign Instr      = w_empty ? '0 : w_head[ISIZE-1:0];
  assign InstrPC    = w_empty ? '0 : w_head[EW-1:ISIZE];

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_fetch;
  logic [15:0] r_perf_flush;
  logic [15:0] w_flush_amt;

  // Entries thrown away by a redirect: everything queued plus the
  // request in flight on the live path (a DISCARD one was already counted).
  assign w_flush_amt = 16'(w_count) + ((r_state == S_WAIT) ? 16'd1 : 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetch <= sat_add16(r_perf_fetch, 16'd1);
      end
      if (PCctrl) begin
        r_perf_flush <= sat_add16(r_perf_flush, w_flush_amt);
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
`default_nettype wire
